// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_mmio
// Brief    : Bus-snooping 8N1 UART transmitter with a small byte FIFO and a
//            registered status word for the memory read mux.
// Revision : 1.0
// ============================================================================
module uart_tx_mmio #(
    parameter int WORD_SIZE      = 16,
    parameter int CLKS_PER_BIT   = 434,
    parameter int FIFO_DEPTH     = 4,
    parameter int TX_DATA_ADDR   = 120,
    parameter int TX_STATUS_ADDR = 119
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 write,
    input  logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic [WORD_SIZE-1:0] status,
    output logic                 tx
);

    localparam int                   c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                   c_BCNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [WORD_SIZE-1:0] c_DATA_ADDR = WORD_SIZE'(TX_DATA_ADDR);
    localparam logic [WORD_SIZE-1:0] c_STAT_ADDR = WORD_SIZE'(TX_STATUS_ADDR);
    localparam logic [c_BCNT_W-1:0]  c_BCNT_LAST = c_BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]           c_FULL_CNT  = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_BCNT_W-1:0]  r_bcnt, w_bcnt_nxt;
    logic [2:0]           r_bidx, w_bidx_nxt;
    logic                 r_tx, w_tx_nxt;
    logic [7:0]           r_shreg;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr, r_wr_ptr;
    logic [4:0]           r_count, w_count_nxt;
    logic                 r_overflow, r_busy, r_full;
    logic                 w_pop, w_push_req, w_push_ok, w_drop, w_clr;
    logic                 w_bcnt_done;
    logic                 w_unused_data;

    assign w_push_req    = write && (addr == c_DATA_ADDR);
    assign w_clr         = write && (addr == c_STAT_ADDR) && data_in[2];
    assign w_bcnt_done   = (r_bcnt == c_BCNT_LAST);
    assign w_unused_data = |data_in[WORD_SIZE-1:8];

    // FSM next-state, serial output and pop decision
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_bidx_nxt  = r_bidx;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (r_count != 5'd0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                    w_bcnt_nxt  = '0;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_bcnt_done) begin
                    w_state_nxt = S_DATA;
                    w_bcnt_nxt  = '0;
                    w_bidx_nxt  = 3'd0;
                    w_tx_nxt    = r_shreg[0];
                end else begin
                    w_bcnt_nxt = r_bcnt + c_BCNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_bcnt_done) begin
                    w_bcnt_nxt = '0;
                    if (r_bidx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bidx_nxt = r_bidx + 3'd1;
                        w_tx_nxt   = r_shreg[r_bidx + 3'd1];
                    end
                end else begin
                    w_bcnt_nxt = r_bcnt + c_BCNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_bcnt_done) begin
                    w_bcnt_nxt = '0;
                    if (r_count != 5'd0) begin
                        // Chain straight into the next start bit, no idle gap
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_bcnt_nxt = r_bcnt + c_BCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    always_comb begin
        w_push_ok = w_push_req && ((r_count != c_FULL_CNT) || w_pop);
        w_drop    = w_push_req && !w_push_ok;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + 5'd1;
            2'b01:   w_count_nxt = r_count - 5'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bcnt     <= '0;
            r_bidx     <= 3'd0;
            r_tx       <= 1'b1;
            r_shreg    <= 8'd0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= 5'd0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_bidx  <= w_bidx_nxt;
            r_tx    <= w_tx_nxt;
            r_count <= w_count_nxt;
            if (w_pop) begin
                r_shreg  <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_clr) begin
                r_overflow <= 1'b0;
            end
            r_busy <= (w_state_nxt != S_IDLE) || (w_count_nxt != 5'd0);
            r_full <= (w_count_nxt == c_FULL_CNT);
        end
    end

    // Storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in[7:0];
        end
    end

    assign tx     = r_tx;
    assign status = {{(WORD_SIZE-9){1'b0}}, r_count, 1'b0, r_overflow, r_busy, r_full};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_mmio
// Brief    : Directed bench for uart_tx_mmio (4 clocks per bit, 4-deep FIFO).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_mmio;

    localparam int c_CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [15:0] data_in = 16'd0;
    logic [15:0] status;
    logic        tx;

    uart_tx_mmio #(
        .WORD_SIZE     (16),
        .CLKS_PER_BIT  (c_CPB),
        .FIFO_DEPTH    (4),
        .TX_DATA_ADDR  (120),
        .TX_STATUS_ADDR(119)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .write  (write),
        .addr   (addr),
        .data_in(data_in),
        .status (status),
        .tx     (tx)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic        exp_tx;
        logic [15:0] exp_status;
    } vec_t;

    vec_t        vt[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          mon_pos = -1;
    int          frame_err = 0;
    logic [7:0]  mon_byte = 8'd0;
    logic [7:0]  rx_q[$];
    int          rx_start[$];
    int          max_cnt;
    logic        ovf_seen;
    int          lows;
    int          qsz;
    logic [7:0]  frame_byte;
    logic [7:0]  e3 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0]  e4 [5] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    logic [7:0]  e5 [5] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};

    // Serial decoder: one sample per clock, mid-bit sampling of each data bit
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            mon_pos = -1;
        end else if (mon_pos < 0) begin
            if (tx == 1'b0) begin
                mon_pos = 0;
                rx_start.push_back(cyc);
            end
        end else begin
            mon_pos++;
            if (mon_pos == 2 && tx !== 1'b0) frame_err++;
            if (mon_pos >= 5 && mon_pos <= 33 && (mon_pos % 4) == 1)
                mon_byte[(mon_pos - 5) / 4] = tx;
            if (mon_pos == 37) begin
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(mon_byte);
            end
            if (mon_pos == 39) mon_pos = -1;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [15:0] a, input logic [15:0] d);
        write   = 1'b1;
        addr    = a;
        data_in = d;
        step();
        write   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_frames(input string name, input logic [7:0] e [5]);
        chk({name, "_nframes"}, 16'(rx_q.size()), 16'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size())
                chk($sformatf("%s_byte%0d", name, i), {8'h00, rx_q[i]}, {8'h00, e[i]});
        end
        for (int i = 1; i < 5; i++) begin
            if (i < rx_start.size())
                chk($sformatf("%s_gap%0d", name, i),
                    16'(rx_start[i] - rx_start[i-1]), 16'(10 * c_CPB));
        end
    endtask

    initial begin
        // Idle after reset, one write of 0x1A5 (upper byte ignored), its full frame
        for (int i = 0; i < 20; i++)
            vt.push_back('{1'b0, 16'd0, 16'd0, 1'b1, 16'h0000});
        vt.push_back('{1'b1, 16'd120, 16'h01A5, 1'b1, 16'h0012});
        frame_byte = 8'hA5;
        for (int k = 1; k <= 40; k++) begin
            if (k <= 4)
                vt.push_back('{1'b0, 16'd0, 16'd0, 1'b0, 16'h0002});
            else if (k <= 36)
                vt.push_back('{1'b0, 16'd0, 16'd0, frame_byte[(k - 5) / 4], 16'h0002});
            else
                vt.push_back('{1'b0, 16'd0, 16'd0, 1'b1, 16'h0002});
        end
        for (int i = 0; i < 3; i++)
            vt.push_back('{1'b0, 16'd0, 16'd0, 1'b1, 16'h0000});

        // Test 1: reset state
        #12;
        chk("rst_tx", {15'd0, tx}, 16'd1);
        chk("rst_status", status, 16'h0000);
        step();
        rst_n = 1'b1;

        // Tests 1-2: table-driven cycle vectors
        for (int i = 0; i < vt.size(); i++) begin
            write   = vt[i].wr;
            addr    = vt[i].a;
            data_in = vt[i].d;
            step();
            chk($sformatf("vec%0d_tx", i), {15'd0, tx}, {15'd0, vt[i].exp_tx});
            chk($sformatf("vec%0d_status", i), status, vt[i].exp_status);
        end
        write = 1'b0;
        chk("t2_byte", 16'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 16'h00A5);
        rx_q.delete();
        rx_start.delete();

        // Test 3: five consecutive writes, back-to-back frames
        bus(16'd120, 16'h0011);
        bus(16'd120, 16'h0022);
        bus(16'd120, 16'h0033);
        bus(16'd120, 16'h0044);
        bus(16'd120, 16'h0055);
        chk("t3_full_status", status, 16'h0043);
        max_cnt  = 0;
        ovf_seen = 1'b0;
        for (int i = 0; i < 205; i++) begin
            if (int'(status[8:4]) > max_cnt) max_cnt = int'(status[8:4]);
            ovf_seen |= status[2];
            step();
        end
        chk("t3_peak_count", 16'(max_cnt), 16'd4);
        chk("t3_overflow", {15'd0, ovf_seen}, 16'd0);
        chk_frames("t3", e3);
        chk("t3_end_status", status, 16'h0000);
        rx_q.delete();
        rx_start.delete();

        // Test 4: sixth write dropped, then overflow cleared
        bus(16'd120, 16'h00C1);
        bus(16'd120, 16'h00C2);
        bus(16'd120, 16'h00C3);
        bus(16'd120, 16'h00C4);
        bus(16'd120, 16'h00C5);
        bus(16'd120, 16'h00C6);
        chk("t4_drop_status", status, 16'h0047);
        bus(16'd119, 16'h0004);
        chk("t4_clear_status", status, 16'h0043);
        idle(205);
        chk_frames("t4", e4);
        chk("t4_end_status", status, 16'h0000);
        rx_q.delete();
        rx_start.delete();

        // Test 5: sticky overflow against non-clearing writes, then a fresh drop
        bus(16'd120, 16'h00D1);
        bus(16'd120, 16'h00D2);
        bus(16'd120, 16'h00D3);
        bus(16'd120, 16'h00D4);
        bus(16'd120, 16'h00D5);
        bus(16'd120, 16'h00D6);
        chk("t5_drop_status", status, 16'h0047);
        bus(16'd119, 16'h00FB);
        chk("t5_noclr_bit2", status, 16'h0047);
        bus(16'd121, 16'h00EE);
        chk("t5_other_addr", status, 16'h0047);
        bus(16'd119, 16'h0004);
        chk("t5_clear", status, 16'h0043);
        bus(16'd120, 16'h00E7);
        chk("t5_redrop", status, 16'h0047);
        bus(16'd119, 16'h0004);
        idle(200);
        chk_frames("t5", e5);
        chk("t5_end_status", status, 16'h0000);
        rx_q.delete();
        rx_start.delete();

        // Test 6: reset during data bit 3 of 0x52 with another byte queued
        bus(16'd120, 16'h0052);
        bus(16'd120, 16'h0077);
        idle(17);
        chk("t6_in_bit3", {15'd0, tx}, 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tx", {15'd0, tx}, 16'd1);
        chk("t6_rst_status", status, 16'h0000);
        idle(2);
        rst_n = 1'b1;
        qsz  = rx_q.size();
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx !== 1'b1) lows++;
        end
        chk("t6_no_residual_low", 16'(lows), 16'd0);
        chk("t6_no_residual_frame", 16'(rx_q.size()), 16'(qsz));
        chk("t6_post_status", status, 16'h0000);
        chk("framing_errors", 16'(frame_err), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
